// File: rtl/mem_dcache_ctrl.sv
// Data-cache request controller between the MEM stage and the dcache: IDLE -> BUSY -> DONE handshake.
// Optional performance counters are enabled by defining MEM_DCACHE_CTRL_PERF_EN.
module mem_dcache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_enable,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_byte_enable,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp,
    output logic [31:0] rdata_out,
    output logic        mem_stall,
    output logic        req_err,
    output logic [31:0] perf_req_count,
    output logic [31:0] perf_stall_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        dcache_read_q, dcache_read_d;
    logic        dcache_write_q, dcache_write_d;
    logic [31:0] dcache_addr_q, dcache_addr_d;
    logic [31:0] dcache_wdata_q, dcache_wdata_d;
    logic [3:0]  dcache_be_q, dcache_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_err_q, req_err_d;
    logic        start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            dcache_read_q  <= 1'b0;
            dcache_write_q <= 1'b0;
            dcache_addr_q  <= '0;
            dcache_wdata_q <= '0;
            dcache_be_q    <= '0;
            rdata_q        <= '0;
            req_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            dcache_read_q  <= dcache_read_d;
            dcache_write_q <= dcache_write_d;
            dcache_addr_q  <= dcache_addr_d;
            dcache_wdata_q <= dcache_wdata_d;
            dcache_be_q    <= dcache_be_d;
            rdata_q        <= rdata_d;
            req_err_q      <= req_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dcache_read_d  = dcache_read_q;
        dcache_write_d = dcache_write_q;
        dcache_addr_d  = dcache_addr_q;
        dcache_wdata_d = dcache_wdata_q;
        dcache_be_d    = dcache_be_q;
        rdata_d        = rdata_q;
        req_err_d      = req_err_q;
        mem_stall      = 1'b0;
        start          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_read || req_write) begin
                    mem_stall      = 1'b1;
                    start          = 1'b1;
                    state_d        = S_BUSY;
                    // A simultaneous read+write is issued as a write and flagged.
                    dcache_write_d = req_write;
                    dcache_read_d  = req_read & ~req_write;
                    dcache_addr_d  = req_addr & 32'hFFFF_FFFC;
                    dcache_wdata_d = req_wdata;
                    dcache_be_d    = req_byte_enable;
                    if (req_read && req_write) begin
                        req_err_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                if (dcache_resp) begin
                    if (dcache_read_q) begin
                        rdata_d = dcache_rdata;
                    end
                    dcache_read_d  = 1'b0;
                    dcache_write_d = 1'b0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                // The stalled instruction is still on req_* here; let it retire.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dcache_read        = dcache_read_q;
    assign dcache_write       = dcache_write_q;
    assign dcache_addr        = dcache_addr_q;
    assign dcache_wdata       = dcache_wdata_q;
    assign dcache_byte_enable = dcache_be_q;
    assign rdata_out          = rdata_q;
    assign req_err            = req_err_q;

`ifdef MEM_DCACHE_CTRL_PERF_EN
    logic [31:0] perf_req_count_q, perf_req_count_d;
    logic [31:0] perf_stall_count_q, perf_stall_count_d;

    always_comb begin
        perf_req_count_d   = perf_req_count_q;
        perf_stall_count_d = perf_stall_count_q;
        if (start && (perf_req_count_q != '1)) begin
            perf_req_count_d = perf_req_count_q + 32'd1;
        end
        if (mem_stall && (perf_stall_count_q != '1)) begin
            perf_stall_count_d = perf_stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_req_count_q   <= '0;
            perf_stall_count_q <= '0;
        end else begin
            perf_req_count_q   <= perf_req_count_d;
            perf_stall_count_q <= perf_stall_count_d;
        end
    end

    assign perf_req_count   = perf_req_count_q;
    assign perf_stall_count = perf_stall_count_q;
`else
    assign perf_req_count   = '0;
    assign perf_stall_count = '0;
`endif

endmodule

// File: doc/mem_dcache_ctrl.md
MEM_DCACHE_CTRL -- requirements
Module: mem_dcache_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have: req_read, req_write  in  1 each  access request from mem stage.
REQ-004 SHALL have: req_addr, req_wdata  in  32 each  byte address and store data from mem stage.
REQ-005 SHALL have: req_byte_enable  in  4  store byte mask from mem stage.
REQ-006 SHALL have: dcache_read, dcache_write  out  1 each  registered request to dcache.
REQ-007 SHALL have: dcache_addr, dcache_wdata  out  32 each; dcache_byte_enable  out  4.
REQ-008 SHALL have: dcache_rdata  in  32; dcache_resp  in  1  one-cycle completion pulse.
REQ-009 SHALL have: rdata_out  out  32  held load data back to mem stage.
REQ-010 SHALL have: mem_stall  out  1  pipeline hold for all stages up to and including EX/MEM.
REQ-011 SHALL have: req_err  out  1  sticky flag for simultaneous read+write request.
REQ-012 SHALL have: perf_req_count, perf_stall_count  out  32 each  performance counters.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: when req_read|req_write=1, SHALL latch addr/wdata/byte_enable/kind and enter BUSY next edge; else stay IDLE.
REQ-015 dcache_addr SHALL be latched {req_addr[31:2],2'b00}; wdata and byte_enable latched unchanged.
REQ-016 If req_read and req_write both 1 in IDLE, SHALL issue write only and set req_err (sticky until reset).
REQ-017 BUSY: dcache_read/dcache_write SHALL be driven from latched kind; all dcache outputs SHALL remain stable until dcache_resp.
REQ-018 BUSY with dcache_resp=1: SHALL capture dcache_rdata into rdata_out (reads only), deassert dcache_read/write next edge, enter DONE.
REQ-019 DONE: SHALL ignore req_* for exactly one cycle (same instruction still presented) and return to IDLE.
REQ-020 mem_stall SHALL be combinational: 1 in IDLE with a request pending, 1 in BUSY, 0 in DONE and idle-no-request.
REQ-021 Minimum latency: request seen cycle 0, dcache request cycle 1, resp cycle 1 earliest, DONE cycle 2; stall high cycles 0-1.
REQ-022 dcache_resp outside BUSY SHALL be ignored without state or rdata_out change.
REQ-023 rdata_out SHALL hold its last captured value until next load completes; write completion SHALL leave it unchanged.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, dcache_read=dcache_write=0, dcache_addr/wdata=0, dcache_byte_enable=0, rdata_out=0, req_err=0, both counters 0.
REQ-025 Reset asserted mid-BUSY SHALL abandon the access; a later stray dcache_resp SHALL be ignored per REQ-022.

Configuration
REQ-026 Macro MEM_DCACHE_CTRL_PERF_EN defined: perf_req_count SHALL increment on each IDLE->BUSY transition; perf_stall_count SHALL increment each cycle mem_stall=1; both saturate at 32'hFFFF_FFFF.
REQ-027 Macro undefined: both perf ports SHALL be tied to 0 and no counter flops SHALL be synthesized; all other behaviour identical.

Verification
REQ-028 Load: req_read=1, req_addr=0x0000_1006, dcache_resp after 3 BUSY cycles with rdata=0xDEAD_BEEF -> dcache_addr=0x0000_1004, stall 4 cycles, rdata_out=0xDEAD_BEEF in DONE.
REQ-029 Store: req_write=1, byte_enable=4'b1100, wdata=0x1234_5678, immediate resp -> single-cycle dcache_write, rdata_out unchanged, stall 2 cycles.
REQ-030 Both req_read and req_write=1 -> write issued only, req_err=1 and stays 1 through later clean accesses.
REQ-031 rst driven low in 2nd BUSY cycle, resp pulsed after release -> all outputs 0, state IDLE, resp ignored.
REQ-032 Back-to-back: load then store presented consecutively -> DONE blocks reissue, store begins cycle after DONE; with PERF_EN, perf_req_count=2.
REQ-033 PERF_EN, counters preloaded near saturation via long-latency runs (force) -> perf_stall_count holds at 0xFFFF_FFFF.
